// File: rtl/sssp_pkg.sv
// Shared definitions for the SSSP update write-back path: line geometry,
// phase codes and the packer state encoding.
package sssp_pkg;

    localparam int LINE_W = 512;
    localparam int UPD_W  = 64;
    localparam int LANES  = 8;

    // Real updates carry a zero top byte, so an all-ones word marks a pad lane.
    localparam logic [UPD_W-1:0] PAD_WORD = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic [1:0] CTRL_LOAD = 2'd1;
    localparam logic [1:0] CTRL_RUN  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PACK,
        ST_DRAIN,
        ST_DONE
    } pack_state_t;

endpackage

// File: rtl/sssp_line_fifo.sv
// First-word-fall-through line FIFO; the head line is visible on rd_data
// whenever the FIFO is not empty, and reads as zero when it is.
module sssp_line_fifo
    import sssp_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [LINE_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [LINE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset; the pointers
    // and count define which entries are live, and resetting 8 kbit of
    // storage would only cost a wide reset tree.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sssp_update_packer.sv
// Packs 64-bit SSSP update words eight per 512-bit line and buffers the lines
// for write-back; the input is never stalled, so a full FIFO drops lines.
module sssp_update_packer
    import sssp_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int AF_MARGIN    = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        control,
    input  logic [UPD_W-1:0]  update_in,
    input  logic              update_in_valid,
    input  logic              last_input_in,
    output logic [LINE_W-1:0] line_out,
    output logic              line_out_valid,
    input  logic              line_out_ready,
    output logic              almost_full,
    output logic              overflow,
    output logic [15:0]       line_count,
    output logic              done
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DC_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [DC_W-1:0]  DRAIN_LAST = DC_W'(DRAIN_CYCLES - 1);

    pack_state_t       state;
    logic [UPD_W-1:0]  lanes [LANES];
    logic [2:0]        lane_idx;
    logic [DC_W-1:0]   drain_cnt;
    logic              accept;
    logic              expire;
    logic              push;
    logic              pop;
    logic [3:0]        fill;
    logic [LINE_W-1:0] line_in;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    // The pushed line merges the update arriving this cycle, so a line leaves
    // on the same edge that writes its final lane.
    always_comb begin
        accept  = update_in_valid && (state == ST_PACK || state == ST_DRAIN);
        expire  = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);
        fill    = {1'b0, lane_idx} + {3'b000, accept};
        push    = (accept && lane_idx == 3'd7) || (expire && fill != 4'd0);
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        line_in = '0;
        for (int k = 0; k < LANES; k++) begin
            if (accept && lane_idx == 3'(k))
                line_in[k*UPD_W +: UPD_W] = update_in;
            else if (4'(k) >= fill)
                line_in[k*UPD_W +: UPD_W] = PAD_WORD;
            else
                line_in[k*UPD_W +: UPD_W] = lanes[k];
        end
    end

    assign line_out_valid = !fifo_empty;
    assign pop            = line_out_valid && line_out_ready;

    always_ff @(posedge clk) begin
        if (accept) lanes[lane_idx] <= update_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            lane_idx    <= '0;
            drain_cnt   <= '0;
            line_count  <= '0;
            overflow    <= 1'b0;
            almost_full <= 1'b0;
            done        <= 1'b0;
        end else begin
            almost_full <= (fifo_count >= AF_LEVEL);
            if (push && fifo_full && !pop) overflow <= 1'b1;
            if (push && line_count != 16'hFFFF) line_count <= line_count + 16'd1;
            if (accept) lane_idx <= lane_idx + 3'd1;

            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (control == CTRL_RUN) state <= ST_PACK;
                end
                ST_PACK: begin
                    if (last_input_in) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + DC_W'(1);
                    if (expire) begin
                        lane_idx <= '0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done <= fifo_empty;
                    if (control == CTRL_LOAD) begin
                        state      <= ST_IDLE;
                        line_count <= '0;
                        lane_idx   <= '0;
                        done       <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sssp_line_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (line_in),
        .rd_en   (pop),
        .rd_data (line_out),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_sssp_update_packer.sv
// Directed bench for sssp_update_packer: expected lines are queued as updates
// are driven and compared when the consumer takes them.
module tb_sssp_update_packer;
    import sssp_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        control;
    logic [UPD_W-1:0]  update_in;
    logic              update_in_valid;
    logic              last_input_in;
    logic [LINE_W-1:0] line_out;
    logic              line_out_valid;
    logic              line_out_ready;
    logic              almost_full;
    logic              overflow;
    logic [15:0]       line_count;
    logic              done;

    int                checks   = 0;
    int                failures = 0;
    logic [LINE_W-1:0] sb [$];
    logic [UPD_W-1:0]  m_lanes [LANES];
    int                m_idx = 0;

    sssp_update_packer #(
        .FIFO_DEPTH   (16),
        .AF_MARGIN    (4),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .control         (control),
        .update_in       (update_in),
        .update_in_valid (update_in_valid),
        .last_input_in   (last_input_in),
        .line_out        (line_out),
        .line_out_valid  (line_out_valid),
        .line_out_ready  (line_out_ready),
        .almost_full     (almost_full),
        .overflow        (overflow),
        .line_count      (line_count),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] pack_line(input int n);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LANES; k++)
            l[k*UPD_W +: UPD_W] = (k < n) ? m_lanes[k] : PAD_WORD;
        return l;
    endfunction

    function automatic logic [UPD_W-1:0] mk_word(input int id, input int lane);
        return {8'h00, 24'(id), 8'h00, 24'(lane)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [UPD_W-1:0] w);
        update_in       = w;
        update_in_valid = 1'b1;
        tick();
        update_in_valid = 1'b0;
    endtask

    // Drive one update and mirror it into the model; a full model line is
    // queued as expected output when 'store' says the DUT must keep it.
    task automatic send_m(input logic [UPD_W-1:0] w, input bit store);
        send(w);
        m_lanes[m_idx] = w;
        m_idx++;
        if (m_idx == LANES) begin
            if (store) sb.push_back(pack_line(LANES));
            m_idx = 0;
        end
    endtask

    task automatic send_line(input int id, input bit store);
        for (int k = 0; k < LANES; k++) send_m(mk_word(id, k), store);
    endtask

    always @(negedge clk) begin
        if (!rst && line_out_valid && line_out_ready) begin
            if (sb.size() == 0) check("sb_underflow", LINE_W'(sb.size()), LINE_W'(1));
            else check("line", line_out, sb.pop_front());
        end
    end

    initial begin
        rst             = 1'b1;
        control         = 2'd0;
        update_in       = '0;
        update_in_valid = 1'b0;
        last_input_in   = 1'b0;
        line_out_ready  = 1'b0;
        tick();
        tick();
        check("rst_line_out", line_out, '0);
        check("rst_valid", LINE_W'(line_out_valid), '0);
        check("rst_af", LINE_W'(almost_full), '0);
        check("rst_overflow", LINE_W'(overflow), '0);
        check("rst_line_count", LINE_W'(line_count), '0);
        check("rst_done", LINE_W'(done), '0);
        rst = 1'b0;
        tick();

        // Updates during IDLE are ignored.
        control = CTRL_LOAD;
        for (int k = 0; k < LANES; k++) send(64'h0000_0009_0000_0000 + 64'(k));
        tick();
        tick();
        check("idle_line_count", LINE_W'(line_count), '0);
        check("idle_valid", LINE_W'(line_out_valid), '0);

        // One full line, fall-through latency, clean finish with no pad line.
        control        = CTRL_RUN;
        line_out_ready = 1'b1;
        tick();
        for (int k = 0; k < LANES; k++) send_m(64'h0000_0001_0000_0000 + 64'(k), 1'b1);
        check("lat_valid", LINE_W'(line_out_valid), LINE_W'(1));
        check("lat_line_count", LINE_W'(line_count), LINE_W'(1));
        last_input_in = 1'b1;
        tick();
        last_input_in = 1'b0;
        repeat (5) tick();
        check("full_done", LINE_W'(done), LINE_W'(1));
        check("full_line_count", LINE_W'(line_count), LINE_W'(1));
        check("full_no_pad", LINE_W'(line_out_valid), '0);
        control = CTRL_LOAD;
        tick();
        check("load_clears_count", LINE_W'(line_count), '0);
        check("load_clears_done", LINE_W'(done), '0);

        // Partial line: three updates, the pulse, one trailing update.
        control = CTRL_RUN;
        tick();
        for (int k = 0; k < 3; k++) send_m(mk_word(2, k), 1'b1);
        last_input_in = 1'b1;
        tick();
        last_input_in = 1'b0;
        send_m(mk_word(2, 3), 1'b1);
        sb.push_back(pack_line(m_idx));
        m_idx = 0;
        repeat (6) tick();
        check("pad_done", LINE_W'(done), LINE_W'(1));
        check("pad_line_count", LINE_W'(line_count), LINE_W'(1));
        check("pad_drained", LINE_W'(line_out_valid), '0);
        control = CTRL_LOAD;
        tick();

        // Fill the FIFO with the consumer stalled.
        control        = CTRL_RUN;
        line_out_ready = 1'b0;
        tick();
        for (int id = 0; id < 11; id++) send_line(id, 1'b1);
        tick();
        tick();
        check("af_below", LINE_W'(almost_full), '0);
        send_line(11, 1'b1);
        tick();
        tick();
        check("af_at_level", LINE_W'(almost_full), LINE_W'(1));
        for (int id = 12; id < 16; id++) send_line(id, 1'b1);
        tick();
        check("full_no_overflow", LINE_W'(overflow), '0);

        // Full FIFO: a pop on the completing cycle lets the push through.
        for (int k = 0; k < 7; k++) send_m(mk_word(16, k), 1'b1);
        line_out_ready = 1'b1;
        send_m(mk_word(16, 7), 1'b1);
        line_out_ready = 1'b0;
        tick();
        tick();
        check("push_pop_no_overflow", LINE_W'(overflow), '0);
        check("push_pop_line_count", LINE_W'(line_count), LINE_W'(17));
        send_line(17, 1'b0);
        tick();
        tick();
        check("drop_overflow", LINE_W'(overflow), LINE_W'(1));
        line_out_ready = 1'b1;
        repeat (20) tick();
        check("drained_valid", LINE_W'(line_out_valid), '0);
        check("drained_sb", LINE_W'(sb.size()), '0);
        last_input_in = 1'b1;
        tick();
        last_input_in = 1'b0;
        repeat (5) tick();
        check("stress_done", LINE_W'(done), LINE_W'(1));
        control = CTRL_LOAD;
        tick();

        // Asynchronous reset with a line buffered and a partial line open.
        control        = CTRL_RUN;
        line_out_ready = 1'b0;
        tick();
        send_line(20, 1'b0);
        for (int k = 0; k < 5; k++) send(mk_word(21, k));
        check("pre_rst_valid", LINE_W'(line_out_valid), LINE_W'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", LINE_W'(line_out_valid), '0);
        check("async_rst_line_out", line_out, '0);
        check("async_rst_overflow", LINE_W'(overflow), '0);
        check("async_rst_line_count", LINE_W'(line_count), '0);
        m_idx = 0;
        tick();
        tick();
        rst            = 1'b0;
        line_out_ready = 1'b1;
        tick();
        for (int k = 0; k < LANES; k++) send_m(mk_word(22, k), 1'b1);
        repeat (4) tick();
        check("post_rst_line_count", LINE_W'(line_count), LINE_W'(1));
        check("final_sb_empty", LINE_W'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
